fetch_ctrl: RTL and testbench

Instruction-fetch controller for the cpu_medium core, between the instruction memory port and the decode stage. It owns the fetch PC and issues in-order word reads. Responses land in a 2-entry buffer. It presents one opcode per cycle to decode under a valid/stall handshake, and handles branch redirects by discarding in-flight and buffered instructions.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 71 +++++++
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   BootVectorDefault : default PC of the first fetch after reset
//   fetch_entry_t     : response buffer entry {inst, pc, fault}
//   fetch_state_e     : fetch FSM states
package fetch_pkg;

  localparam logic [31:0] BootVectorDefault = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StFlush
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO with flush, used both as the response buffer and
// as the in-order request tag queue.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empty the FIFO (wins over push/pop)
//   push_i/wdata_i: write an entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry
//   count_o       : number of stored entries (0..2)
module fetch_buf #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues in-order word reads
// with at most two credits (outstanding + buffered), buffers responses in a
// 2-entry FIFO and hands one opcode per cycle to decode. Branches discard all
// buffered and in-flight instructions.
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   mem_rd_o/mem_pc_o    : read request and word address
//   mem_accept_i         : request accepted this cycle
//   mem_valid_i/inst/err : in-order read response
//   branch_i/branch_pc_i : redirect request and target
//   stall_i              : decode not ready
//   opcode_*_o           : head instruction, its PC, valid and fault flag
// Optional feature macro FETCH_FAULT_EN: store mem_error_i per entry and
// present it on opcode_fault_o (opcode_o forced to 0 for faulted entries).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_VECTOR = BootVectorDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_pc_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_error_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  input  logic        stall_i,
  output logic [31:0] opcode_o,
  output logic [31:0] opcode_pc_o,
  output logic        opcode_valid_o,
  output logic        opcode_fault_o
);

`ifdef FETCH_FAULT_EN
  localparam int unsigned EntryW = 65;
`else
  localparam int unsigned EntryW = 64;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   out_q, out_d;
  logic [1:0]   drop_q, drop_d;

  logic [1:0]        buf_count;
  logic [EntryW-1:0] buf_wdata, buf_rdata;
  logic [31:0]       tag_pc;
  logic [1:0]        tag_count;
  logic              acc, push, pop;
  logic [2:0]        credit_used;
  fetch_entry_t      head;

  assign credit_used = {1'b0, out_q} + {1'b0, buf_count};
  assign mem_rd_o    = (state_q == StFetch) && (credit_used < 3'd2) && !branch_i;
  assign mem_pc_o    = pc_q;
  assign acc         = mem_rd_o && mem_accept_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    push    = 1'b0;
    // Outstanding count after this cycle's accept and response, stale or not.
    out_d   = out_q + {1'b0, acc} - {1'b0, mem_valid_i};
    if (acc) begin
      pc_d = pc_q + 32'd4;
    end
    if (branch_i) begin
      // A response landing this cycle is already excluded from out_d.
      pc_d    = {branch_pc_i[31:2], 2'b00};
      drop_d  = out_d;
      state_d = (out_d != 2'd0) ? StFlush : StFetch;
    end else begin
      unique case (state_q)
        StBoot: state_d = StFetch;
        StFetch: push = mem_valid_i && (drop_q == 2'd0);
        StFlush: begin
          if (mem_valid_i && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
            if (drop_q == 2'd1) begin
              state_d = StFetch;
            end
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StBoot;
      pc_q    <= BOOT_VECTOR;
      out_q   <= 2'd0;
      drop_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  // Tag queue mirrors outstanding requests; every response pops one tag,
  // including discarded ones, so it never needs flushing on a branch.
  fetch_buf #(
    .Width (32)
  ) u_tag_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .flush_i (1'b0),
    .push_i  (acc),
    .wdata_i (pc_q),
    .pop_i   (mem_valid_i),
    .rdata_o (tag_pc),
    .count_o (tag_count)
  );

`ifdef FETCH_FAULT_EN
  assign buf_wdata = {(mem_error_i ? 32'd0 : mem_inst_i), tag_pc, mem_error_i};
  assign head      = buf_rdata;
`else
  logic unused_err;
  assign unused_err = mem_error_i;
  assign buf_wdata  = {mem_inst_i, tag_pc};
  assign head       = {buf_rdata, 1'b0};
`endif

  logic [1:0] unused_tag_count;
  assign unused_tag_count = tag_count;

  fetch_buf #(
    .Width (EntryW)
  ) u_resp_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .flush_i (branch_i),
    .push_i  (push),
    .wdata_i (buf_wdata),
    .pop_i   (pop),
    .rdata_o (buf_rdata),
    .count_o (buf_count)
  );

  assign opcode_valid_o = (buf_count != 2'd0) && !branch_i;
  assign pop            = opcode_valid_o && !stall_i;
  assign opcode_o       = head.inst;
  assign opcode_pc_o    = head.pc;
  assign opcode_fault_o = head.fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory model answers accepted requests
// after a random latency; the expected decode stream is the sequential
// program trace starting at the boot vector or the last branch target.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_rd_o;
  logic [31:0] mem_pc_o;
  logic        mem_accept_i;
  logic        mem_valid_i;
  logic [31:0] mem_inst_i;
  logic        mem_error_i;
  logic        branch_i;
  logic [31:0] branch_pc_i;
  logic        stall_i;
  logic [31:0] opcode_o;
  logic [31:0] opcode_pc_o;
  logic        opcode_valid_o;
  logic        opcode_fault_o;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .mem_rd_o       (mem_rd_o),
    .mem_pc_o       (mem_pc_o),
    .mem_accept_i   (mem_accept_i),
    .mem_valid_i    (mem_valid_i),
    .mem_inst_i     (mem_inst_i),
    .mem_error_i    (mem_error_i),
    .branch_i       (branch_i),
    .branch_pc_i    (branch_pc_i),
    .stall_i        (stall_i),
    .opcode_o       (opcode_o),
    .opcode_pc_o    (opcode_pc_o),
    .opcode_valid_o (opcode_valid_o),
    .opcode_fault_o (opcode_fault_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } req_t;

  exp_t        exp_q[$];
  req_t        pend[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          pops = 0;
  logic [31:0] next_pc;
  logic [31:0] req_exp;
  logic        saw_zero_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC001_D00D;
  endfunction

  function automatic logic err_of(input logic [31:0] pc);
    return (pc == 32'h108) || (pc[6:2] == 5'd19);
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
`ifdef FETCH_FAULT_EN
    e.fault = err_of(pc);
    e.inst  = e.fault ? 32'd0 : inst_of(pc);
`else
    e.fault = 1'b0;
    e.inst  = inst_of(pc);
`endif
    return e;
  endfunction

  // One clock cycle: drive inputs at the falling edge, then track accepts.
  task automatic step(input logic br, input logic [31:0] tgt, input logic stl,
                      input logic acc, input int lat);
    @(negedge clk);
    cyc++;
    branch_i     = br;
    branch_pc_i  = tgt;
    stall_i      = stl;
    mem_accept_i = acc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_valid_i = 1'b1;
      mem_inst_i  = inst_of(pend[0].pc);
      mem_error_i = err_of(pend[0].pc);
      void'(pend.pop_front());
    end else begin
      mem_valid_i = 1'b0;
      mem_inst_i  = $urandom;
      mem_error_i = 1'($urandom_range(0, 1));
    end
    if (br) begin
      exp_q.delete();
      next_pc = {tgt[31:2], 2'b00};
      req_exp = {tgt[31:2], 2'b00};
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(mk_exp(next_pc));
      next_pc = next_pc + 32'd4;
    end
    #1;
    if (br) check("no_req_in_branch", mem_rd_o, 1'b0);
    if (mem_rd_o && acc) begin
      check("req_addr", mem_pc_o, req_exp);
      req_exp = req_exp + 32'd4;
      pend.push_back('{pc: mem_pc_o, due: cyc + lat});
      check("credit_limit", 32'(pend.size() <= 2), 32'd1);
    end
  endtask

  // Reset asserted at a falling edge, released just after a rising edge so
  // the next full cycle is the boot cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_i        = 1'b0;
    branch_i     = 1'b0;
    branch_pc_i  = '0;
    stall_i      = 1'b0;
    mem_accept_i = 1'b0;
    mem_valid_i  = 1'b0;
    mem_inst_i   = '0;
    mem_error_i  = 1'b0;
    pend.delete();
    exp_q.delete();
    next_pc = 32'h100;
    req_exp = 32'h100;
    #1;
    check("rst_mem_rd", mem_rd_o, 1'b0);
    check("rst_mem_pc", mem_pc_o, 32'h100);
    check("rst_valid", opcode_valid_o, 1'b0);
    check("rst_opcode", opcode_o, 32'd0);
    check("rst_opcode_pc", opcode_pc_o, 32'd0);
    check("rst_fault", opcode_fault_o, 1'b0);
    @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend.size() > 0 && n < 20) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1);
      n++;
    end
    check("idle_timeout", 32'(pend.size()), 32'd0);
  endtask

  // After a branch: no request until the last stale response, then target.
  task automatic drain_check(input logic [31:0] tgt);
    int n = 0;
    while (pend.size() > 0 && n < 20) begin
      step(1'b0, 32'd0, 1'b0, 1'b1, 1);
      check("flush_no_req", mem_rd_o, 1'b0);
      n++;
    end
    check("flush_timeout", 32'(pend.size()), 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("flush_then_req", mem_rd_o, 1'b1);
    check("flush_target_pc", mem_pc_o, {tgt[31:2], 2'b00});
  endtask

  // Monitor: compares every handed-over opcode against the scoreboard.
  logic        prev_v, prev_stall, prev_br;
  logic [31:0] prev_op, prev_pc;
  exp_t        mon_e;

  always begin
    @(negedge clk);
    #2;
    if (!rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (branch_i) check("valid_low_on_branch", opcode_valid_o, 1'b0);
      if (prev_v && prev_stall && !prev_br) begin
        check("stall_hold_opcode", opcode_o, prev_op);
        check("stall_hold_pc", opcode_pc_o, prev_pc);
      end
      if (opcode_valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_opcode_pc", opcode_pc_o, 32'hxxxx_xxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check("opcode_pc", opcode_pc_o, mon_e.pc);
          check("opcode", opcode_o, mon_e.inst);
          check("opcode_fault", opcode_fault_o, mon_e.fault);
          if (opcode_pc_o == 32'd0) saw_zero_pc = 1'b1;
          pops++;
        end
      end
      prev_v     = opcode_valid_o;
      prev_stall = stall_i;
      prev_br    = branch_i;
      prev_op    = opcode_o;
      prev_pc    = opcode_pc_o;
    end
  end

  initial begin
    logic [31:0] tgt;
    rst_i       = 1'b0;
    saw_zero_pc = 1'b0;
    do_reset();

    // Startup with 1-cycle memory: boot cycle, request, response, valid.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("boot_no_req", mem_rd_o, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("first_req", mem_rd_o, 1'b1);
    check("first_req_pc", mem_pc_o, 32'h100);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("valid_c2", opcode_valid_o, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("valid_c3", opcode_valid_o, 1'b1);
    repeat (8) step(1'b0, 32'd0, 1'b0, 1'b1, 1);

    // Stall long enough to fill both entries.
    repeat (5) step(1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("stall_full_no_req", mem_rd_o, 1'b0);
    check("stall_valid", opcode_valid_o, 1'b1);
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1, 1);

    // Branch with no outstanding requests: target requested next cycle.
    wait_idle();
    step(1'b1, 32'h3000, 1'b0, 1'b0, 1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 5);
    check("branch_next_req", mem_rd_o, 1'b1);
    check("branch_next_pc", mem_pc_o, 32'h3000);
    step(1'b0, 32'd0, 1'b0, 1'b1, 5);
    // Two outstanding, branch to an unaligned target.
    step(1'b1, 32'h2002, 1'b0, 1'b0, 1);
    drain_check(32'h2002);
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1, 1);

    // Branch coincides with a response: only one stale response remains.
    wait_idle();
    step(1'b1, 32'h4000, 1'b0, 1'b0, 1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 2);
    step(1'b0, 32'd0, 1'b0, 1'b1, 2);
    step(1'b1, 32'h5000, 1'b0, 1'b1, 1);
    check("branch_rsp_valid_low", opcode_valid_o, 1'b0);
    drain_check(32'h5000);
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1, 1);

    // Address wrap.
    wait_idle();
    saw_zero_pc = 1'b0;
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("wrap_first_pc", mem_pc_o, 32'hFFFF_FFFC);
    repeat (8) step(1'b0, 32'd0, 1'b0, 1'b1, 1);
    check("wrap_seen_zero", saw_zero_pc, 1'b1);

    // Randomised traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      logic br;
      if (i == 1500) do_reset();
      br = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(br, tgt, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(1, 3));
    end
    check("progress", 32'(pops > 500), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
